// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Decode-side control, instruction-memory and IF/ID signals of the
//            fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if #(
   parameter int COUNT_W = 16
);
   logic               Stall;
   logic               Flush;
   logic               BranchTaken;
   logic [31:0]        BranchTarget;
   logic               Jump;
   logic [25:0]        JumpIndex;
   logic               Jr;
   logic [31:0]        JrTarget;
   logic [31:0]        ImemData;
   logic [31:0]        ImemAddr;
   logic [31:0]        PC;
   logic [31:0]        IFID_Instruction;
   logic [31:0]        IFID_PCPlus4;
   logic               IFID_Valid;
   logic [COUNT_W-1:0] FetchCount;

   // Decode/memory side: drives controls and the returned word.
   modport master (
      output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpIndex,
             Jr, JrTarget, ImemData,
      input  ImemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
             FetchCount
   );

   // Fetch stage side.
   modport slave (
      input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpIndex,
             Jr, JrTarget, ImemData,
      output ImemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
             FetchCount
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Program counter, next-PC selection and IF/ID pipeline register
//            with a saturating count of delivered instructions.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          COUNT_W  = 16
) (
   input  wire logic   Clk,
   input  wire logic   Reset,
   fetch_stage_if.slave fif
);
   localparam logic [COUNT_W-1:0] c_count_max = '1;
   localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

   logic [31:0]        r_pc;
   logic [31:0]        r_ifid_instr;
   logic [31:0]        r_ifid_pcplus4;
   logic               r_ifid_valid;
   logic [COUNT_W-1:0] r_fetch_count;

   logic [31:0]        w_pc_plus4;
   logic               w_redirect;
   logic [31:0]        w_target;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_redirect = fif.Jr | fif.Jump | fif.BranchTaken;

   // Jr outranks Jump, which outranks a taken branch; word alignment forced.
   always_comb begin
      w_target = {fif.BranchTarget[31:2], 2'b00};
      if (fif.Jr) begin
         w_target = {fif.JrTarget[31:2], 2'b00};
      end else if (fif.Jump) begin
         w_target = {r_ifid_pcplus4[31:28], fif.JumpIndex, 2'b00};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pc           <= RESET_PC;
         r_ifid_instr   <= 32'h00000000;
         r_ifid_pcplus4 <= 32'h00000000;
         r_ifid_valid   <= 1'b0;
         r_fetch_count  <= '0;
      end else if (w_redirect) begin
         r_pc           <= w_target;
         r_ifid_instr   <= 32'h00000000;
         r_ifid_pcplus4 <= 32'h00000000;
         r_ifid_valid   <= 1'b0;
      end else if (fif.Flush) begin
         r_ifid_instr   <= 32'h00000000;
         r_ifid_pcplus4 <= 32'h00000000;
         r_ifid_valid   <= 1'b0;
         if (!fif.Stall) begin
            r_pc <= w_pc_plus4;
         end
      end else if (!fif.Stall) begin
         r_pc           <= w_pc_plus4;
         r_ifid_instr   <= fif.ImemData;
         r_ifid_pcplus4 <= w_pc_plus4;
         r_ifid_valid   <= 1'b1;
         if (r_fetch_count != c_count_max) begin
            r_fetch_count <= r_fetch_count + c_count_one;
         end
      end
   end

   assign fif.ImemAddr         = r_pc;
   assign fif.PC               = r_pc;
   assign fif.IFID_Instruction = r_ifid_instr;
   assign fif.IFID_PCPlus4     = r_ifid_pcplus4;
   assign fif.IFID_Valid       = r_ifid_valid;
   assign fif.FetchCount       = r_fetch_count;
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode Controller.
- Holds the program counter and computes the next PC from sequential, branch, jump, jal and jr redirects.
- Drives the instruction-memory address and latches the returned word into the IF/ID pipeline register. Decode, including the Controller, consumes that register.
- Supports decode stalls and flushes.
- Keeps a saturating count of instructions delivered.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; low two bits are 0.
- COUNT_W, 16, width of the FetchCount counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold PC and IF/ID (load-use hazard from decode).
- Flush  input  1  replace the IF/ID contents with a bubble on the next edge.
- BranchTaken  input  1  a branch resolved in decode is taken.
- BranchTarget  input  32  absolute branch target.
- Jump  input  1  j/jal in decode.
- JumpIndex  input  26  instr_index field of the j/jal in decode.
- Jr  input  1  jr in decode.
- JrTarget  input  32  register value for jr.
- ImemData  input  32  instruction word; combinational read of ImemAddr.
- ImemAddr  output  32  equals PC.
- PC  output  32  current fetch PC.
- IFID_Instruction  output  32  instruction presented to decode/Controller.
- IFID_PCPlus4  output  32  PC+4 of the instruction in IF/ID.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
- FetchCount  output  COUNT_W  number of valid instructions loaded into IF/ID, saturating.

Behaviour:
- Reset (async, active-high, any time including mid-redirect):
  - PC = RESET_PC.
  - IFID_Instruction = 32'h00000000 (sll $0 nop).
  - IFID_PCPlus4 = 0, IFID_Valid = 0, FetchCount = 0.
  - First edge after deassertion fetches RESET_PC.
- ImemAddr = PC, combinational. The fetch latency is 1 cycle: the word at PC appears on IFID_Instruction after the next edge.
- Redirect = Jr | Jump | BranchTaken. Target priority is Jr > Jump > BranchTaken:
  - Jr target = {JrTarget[31:2], 2'b00}; low bits are masked.
  - Jump target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - Branch target = {BranchTarget[31:2], 2'b00}.
- Per-edge update, highest priority first:
  1. Redirect: PC <= target; IF/ID <= bubble (Instruction 0, PCPlus4 0, Valid 0). Redirect overrides Stall and Flush. This gives a 1-cycle taken-branch/jump penalty.
  2. Flush (no redirect): IF/ID <= bubble. PC <= PC+4 if Stall=0; PC held if Stall=1.
  3. Stall (no redirect, no flush): PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid all hold.
  4. Otherwise: IFID_Instruction <= ImemData; IFID_PCPlus4 <= PC+4; IFID_Valid <= 1; PC <= PC+4.
- PC+4 is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
- FetchCount:
  - Increments only on edges taking case 4.
  - Saturates at 2^COUNT_W-1.
  - Not cleared by Flush or Stall.
- No internal combinational path from ImemData to any output except through the IF/ID register.
- jal link value is IFID_PCPlus4. This block does not generate it; decode/writeback use it.

Test Plan:
- Reset deasserted, ImemData returns word = address: over 4 cycles PC = 0,4,8,C; IFID_Instruction = 0,4,8; IFID_Valid rises 1 cycle after reset release; FetchCount = 3 after 3 edges.
- At PC=0x10 assert Stall for 2 cycles: PC stays 0x10, IF/ID holds 0x0C/PCPlus4 0x10, FetchCount frozen; resumes at 0x14 after release.
- With IFID_PCPlus4=0x30000008: Jump=1, JumpIndex=26'h40 -> PC=0x30000100 next edge, IFID_Valid=0 for that cycle. Then Jr=1, Jump=1, BranchTaken=1 together with JrTarget=0x203 -> PC=0x200 (Jr wins, mask applied).
- Stall=1 and BranchTaken=1 (target 0x80) same cycle -> PC=0x80, bubble. Flush=1 with Stall=1 -> bubble, PC held.
- PC=32'hFFFFFFFC, no control -> next PC=0, IFID_PCPlus4=0. With COUNT_W=2, five sequential fetches -> FetchCount saturates at 3.
- Assert Reset asynchronously between edges during a redirect -> all outputs return to reset values immediately, without waiting for Clk.
